// File: rtl/turf_dio_bridge.sv
// PLX local-bus (nCS3 region) to TURF_DIO bridge: each 32-bit word becomes an
// address beat plus four byte beats on the 8-bit TURF bus, with nREADY back to the PLX.
module turf_dio_bridge (
  input  logic        BCLKO,
  input  logic        nRST,
  input  logic        nADS,
  input  logic        WnR,
  input  logic        nBLAST,
  input  logic        nCS3,
  input  logic [9:2]  LA,
  input  logic [31:0] LD_I,
  output logic [31:0] LD_O,
  output logic        LD_OE,
  output logic        nREADY,
  output logic        nBTERM,
  input  logic [7:0]  DIO_I,
  output logic [7:0]  DIO_O,
  output logic        DIO_OE,
  output logic        nCSTURF,
  output logic        TURF_WnR
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    TA    = 3'd2,
    WDATA = 3'd3,
    RDATA = 3'd4,
    ACK   = 3'd5,
    GAP   = 3'd6
  } state_t;

  state_t      state;
  logic [1:0]  beat;
  logic [7:0]  addr;
  logic        wr;
  logic        cont;
  logic [23:0] wdata;
  logic [23:0] rdata;
  logic        accept;

  assign accept = ~nADS & ~nCS3;
  assign nBTERM = 1'b1;

  // Transaction sequencer; every pin output is registered here.
  always_ff @(posedge BCLKO or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      beat     <= 2'd0;
      addr     <= 8'h00;
      wr       <= 1'b0;
      cont     <= 1'b0;
      wdata    <= 24'h000000;
      rdata    <= 24'h000000;
      LD_O     <= 32'h00000000;
      LD_OE    <= 1'b0;
      nREADY   <= 1'b1;
      DIO_O    <= 8'h00;
      DIO_OE   <= 1'b0;
      nCSTURF  <= 1'b1;
      TURF_WnR <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr     <= LA;
            wr       <= WnR;
            state    <= ADDR;
            nCSTURF  <= 1'b0;
            DIO_OE   <= 1'b1;
            DIO_O    <= LA;
            TURF_WnR <= WnR;
            LD_OE    <= ~WnR;
          end else begin
            state <= IDLE;
          end
        end
        ADDR: begin
          beat <= 2'd0;
          if (wr) begin
            // Byte 0 goes straight out; the upper three bytes are shifted out later.
            wdata  <= LD_I[31:8];
            DIO_O  <= LD_I[7:0];
            DIO_OE <= 1'b1;
            state  <= WDATA;
          end else begin
            DIO_O  <= 8'h00;
            DIO_OE <= 1'b0;
            state  <= TA;
          end
        end
        TA: begin
          beat  <= 2'd0;
          state <= RDATA;
        end
        WDATA: begin
          if (beat == 2'd3) begin
            DIO_O  <= 8'h00;
            DIO_OE <= 1'b0;
            nREADY <= 1'b0;
            state  <= ACK;
          end else begin
            DIO_O <= wdata[7:0];
            wdata <= {8'h00, wdata[23:8]};
            beat  <= beat + 2'd1;
          end
        end
        RDATA: begin
          case (beat)
            2'd0:    rdata[7:0]   <= DIO_I;
            2'd1:    rdata[15:8]  <= DIO_I;
            2'd2:    rdata[23:16] <= DIO_I;
            default: rdata        <= rdata;
          endcase
          if (beat == 2'd3) begin
            LD_O   <= {DIO_I, rdata};
            nREADY <= 1'b0;
            state  <= ACK;
          end else begin
            beat <= beat + 2'd1;
          end
        end
        ACK: begin
          nREADY  <= 1'b1;
          nCSTURF <= 1'b1;
          DIO_OE  <= 1'b0;
          state   <= GAP;
          if (!nBLAST) begin
            cont  <= 1'b0;
            LD_OE <= 1'b0;
          end else begin
            addr  <= addr + 8'd1;
            cont  <= 1'b1;
            LD_OE <= ~wr;
          end
        end
        GAP: begin
          if (cont) begin
            cont    <= 1'b0;
            nCSTURF <= 1'b0;
            DIO_OE  <= 1'b1;
            DIO_O   <= addr;
            LD_OE   <= ~wr;
            state   <= ADDR;
          end else if (accept) begin
            // A fresh access may start right at the end of the gap.
            addr     <= LA;
            wr       <= WnR;
            nCSTURF  <= 1'b0;
            DIO_OE   <= 1'b1;
            DIO_O    <= LA;
            TURF_WnR <= WnR;
            LD_OE    <= ~WnR;
            state    <= ADDR;
          end else begin
            LD_OE <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          nREADY  <= 1'b1;
          nCSTURF <= 1'b1;
          DIO_OE  <= 1'b0;
          LD_OE   <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_turf_dio_bridge.sv
// Directed plus randomized bench for turf_dio_bridge; a cycle-position model of each
// word (ADDR at position 0, nREADY at L-2, GAP at L-1) predicts every pin.
module tb_turf_dio_bridge;

  logic        BCLKO = 1'b0;
  logic        nRST;
  logic        nADS, WnR, nBLAST, nCS3;
  logic [9:2]  LA;
  logic [31:0] LD_I, LD_O;
  logic        LD_OE, nREADY, nBTERM;
  logic [7:0]  DIO_I, DIO_O;
  logic        DIO_OE, nCSTURF, TURF_WnR;

  int tests = 0;
  int fails = 0;
  logic [31:0] wq[4];

  turf_dio_bridge dut (
    .BCLKO(BCLKO), .nRST(nRST), .nADS(nADS), .WnR(WnR), .nBLAST(nBLAST),
    .nCS3(nCS3), .LA(LA), .LD_I(LD_I), .LD_O(LD_O), .LD_OE(LD_OE),
    .nREADY(nREADY), .nBTERM(nBTERM), .DIO_I(DIO_I), .DIO_O(DIO_O),
    .DIO_OE(DIO_OE), .nCSTURF(nCSTURF), .TURF_WnR(TURF_WnR)
  );

  always #5 BCLKO = ~BCLKO;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge BCLKO);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, " nREADY"},   32'(nREADY),   32'd1);
    chk({tag, " nBTERM"},   32'(nBTERM),   32'd1);
    chk({tag, " nCSTURF"},  32'(nCSTURF),  32'd1);
    chk({tag, " TURF_WnR"}, 32'(TURF_WnR), 32'd0);
    chk({tag, " DIO_OE"},   32'(DIO_OE),   32'd0);
    chk({tag, " DIO_O"},    32'(DIO_O),    32'd0);
    chk({tag, " LD_OE"},    32'(LD_OE),    32'd0);
    chk({tag, " LD_O"},     LD_O,          32'd0);
  endtask

  // Idle cycles: no transaction may be running.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      nADS = 1'b1;
      nCS3 = 1'($urandom);
      chk($sformatf("idle%0d nCSTURF", i), 32'(nCSTURF), 32'd1);
      chk($sformatf("idle%0d nREADY", i),  32'(nREADY),  32'd1);
      chk($sformatf("idle%0d DIO_OE", i),  32'(DIO_OE),  32'd0);
      chk($sformatf("idle%0d LD_OE", i),   32'(LD_OE),   32'd0);
    end
  endtask

  // Issue ADS in the current cycle, then check every cycle of an n-word burst.
  // Returns while observing the final GAP cycle, without stepping past it.
  task automatic run_burst(input bit w, input logic [7:0] a0, input int n, input bit noise);
    int          len;
    logic [7:0]  a;
    logic [31:0] word;
    string       t;
    len    = w ? 7 : 8;
    nADS   = 1'b0;
    nCS3   = 1'b0;
    WnR    = w;
    LA     = a0;
    LD_I   = $urandom;
    DIO_I  = 8'($urandom);
    nBLAST = 1'($urandom);
    step();
    for (int k = 0; k < n; k++) begin
      a    = a0 + 8'(k);
      word = wq[k];
      for (int j = 0; j < len; j++) begin
        t      = $sformatf("%s a%02h w%0d c%0d", w ? "wr" : "rd", a0, k, j);
        nADS   = (noise && j < len - 1) ? 1'($urandom) : 1'b1;
        nCS3   = noise ? 1'b0 : 1'($urandom);
        WnR    = 1'($urandom);
        LA     = 8'($urandom);
        LD_I   = (w && j == 0) ? word : $urandom;
        DIO_I  = (!w && j >= 2 && j <= 5) ? 8'(word >> (8 * (j - 2))) : 8'($urandom);
        nBLAST = (j == len - 2) ? ((k == n - 1) ? 1'b0 : 1'b1) : 1'($urandom);
        chk({t, " nCSTURF"}, 32'(nCSTURF), (j == len - 1) ? 32'd1 : 32'd0);
        chk({t, " nREADY"},  32'(nREADY),  (j == len - 2) ? 32'd0 : 32'd1);
        chk({t, " nBTERM"},  32'(nBTERM),  32'd1);
        chk({t, " DIO_OE"},  32'(DIO_OE),  (w ? (j <= 4) : (j == 0)) ? 32'd1 : 32'd0);
        chk({t, " LD_OE"},   32'(LD_OE),
            (!w && (j < len - 1 || k < n - 1)) ? 32'd1 : 32'd0);
        if (j == 0) begin
          chk({t, " DIO_O addr"}, 32'(DIO_O), 32'(a));
          chk({t, " TURF_WnR"},   32'(TURF_WnR), 32'(w));
        end
        if (w && j >= 1 && j <= 4)
          chk({t, " DIO_O data"}, 32'(DIO_O), 32'(8'(word >> (8 * (j - 1)))));
        if (!w && j == len - 2)
          chk({t, " LD_O"}, LD_O, word);
        if (!(k == n - 1 && j == len - 1))
          step();
      end
    end
  endtask

  initial begin
    bit          w;
    int          n;
    logic [7:0]  a0;
    nRST = 1'b0; nADS = 1'b1; WnR = 1'b0; nBLAST = 1'b1; nCS3 = 1'b1;
    LA = 8'h00; LD_I = 32'h0; DIO_I = 8'h00;
    #12;
    chk_reset_outs("reset");
    #1 nRST = 1'b1;
    step();

    // Single write from the plan.
    wq[0] = 32'hA1B2C3D4;
    run_burst(1'b1, 8'h12, 1, 1'b0);
    nADS = 1'b1;
    idle(2);

    // Single read from the plan.
    wq[0] = 32'h12345678;
    run_burst(1'b0, 8'h34, 1, 1'b0);
    nADS = 1'b1;
    idle(1);

    // Write burst across the address wrap.
    wq[0] = 32'h11223344; wq[1] = 32'h55667788; wq[2] = 32'h99AABBCC;
    run_burst(1'b1, 8'hFE, 3, 1'b0);
    nADS = 1'b1;
    idle(1);

    // ADS in another region is ignored; the later one runs normally.
    nADS = 1'b0; nCS3 = 1'b1; WnR = 1'b1; LA = 8'h5A;
    idle(4);
    wq[0] = 32'hCAFEF00D;
    run_burst(1'b1, 8'h21, 1, 1'b0);
    nADS = 1'b1;
    idle(1);

    // Reset during read beat 2, then a clean read.
    nADS = 1'b0; nCS3 = 1'b0; WnR = 1'b0; LA = 8'h40;
    step();
    nADS = 1'b1;
    for (int j = 0; j < 4; j++) begin
      DIO_I = 8'($urandom);
      step();
    end
    #2 nRST = 1'b0;
    #1 chk_reset_outs("async rst");
    step();
    chk_reset_outs("held rst");
    #2 nRST = 1'b1;
    step();
    wq[0] = 32'h0BADBEEF;
    run_burst(1'b0, 8'h41, 1, 1'b0);
    nADS = 1'b1;
    idle(1);

    // ADS noise during an active write produces no extra transaction.
    wq[0] = 32'h600DD00D;
    run_burst(1'b1, 8'h77, 1, 1'b1);
    nADS = 1'b1;
    idle(6);

    // Read burst across the wrap, with a back-to-back write started in the gap.
    wq[0] = 32'hDEADBEEF; wq[1] = 32'h01020304;
    run_burst(1'b0, 8'hFF, 2, 1'b0);
    wq[0] = 32'h87654321;
    run_burst(1'b1, 8'h03, 1, 1'b0);
    nADS = 1'b1;
    idle(1);

    // Randomized bursts.
    for (int r = 0; r < 12; r++) begin
      w  = 1'($urandom);
      n  = $urandom_range(1, 4);
      a0 = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(252, 255)) : 8'($urandom);
      for (int k = 0; k < 4; k++) wq[k] = $urandom;
      run_burst(w, a0, n, 1'b0);
      nADS = 1'b1;
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
    end
    idle(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/turf_dio_bridge.md
# turf_dio_bridge

Local-bus target controller that sequences 32-bit PLX local-bus accesses in the nCS3 region onto the 8-bit bidirectional TURF_DIO bus. Each word becomes one TURF transaction: an address beat, then four byte beats. The block generates nREADY back to the PLX and handles burst continuation. It sits between the local-bus pins and the TURF interface pins in the top level; the top level instantiates the IOBUFs.

## Interface
Parameters:
- None. Beat count, address width and turnaround are fixed.

Ports:
- BCLKO  in  1  local-bus clock; the block's only clock.
- nRST  in  1  reset, asynchronous and active-low.
- nADS  in  1  address strobe, active-low.
- WnR  in  1  1 = write, 0 = read; valid with nADS.
- nBLAST  in  1  last-data indicator, active-low.
- nCS3  in  1  TURF region chip select, active-low.
- LA  in  [9:2]  word address; bits above 9 are not used here.
- LD_I  in  32  local data in (write data).
- LD_O  out  32  local data out (read data).
- LD_OE  out  1  high while this block drives LD.
- nREADY  out  1  data-ready, active-low.
- nBTERM  out  1  held 1 at all times.
- DIO_I  in  8  TURF_DIO input.
- DIO_O  out  8  TURF_DIO output.
- DIO_OE  out  1  high while this block drives TURF_DIO.
- nCSTURF  out  1  TURF transaction strobe, active-low.
- TURF_WnR  out  1  direction to TURF, 1 = write.

## Operation
- Registered FSM states: IDLE, ADDR, TA, WDATA, RDATA, ACK, GAP. A 2-bit beat counter `beat` and an 8-bit address register `addr` support the FSM.
- IDLE:
  - If nADS=0 and nCS3=0 at an edge, latch `addr`←LA[9:2] and `wr`←WnR, then go to ADDR.
  - Otherwise stay in IDLE.
- ADDR:
  - nCSTURF=0, DIO_OE=1, DIO_O=`addr`, TURF_WnR=`wr`.
  - If `wr`=1, latch `wdata`←LD_I and go to WDATA.
  - If `wr`=0, go to TA.
- TA: nCSTURF=0, DIO_OE=0, for exactly one cycle, then go to RDATA.
- WDATA, beat k = 0..3:
  - DIO_OE=1, DIO_O=`wdata`[8k+7:8k], LSB first.
  - When beat 3 completes, go to ACK.
- RDATA, beat k = 0..3:
  - DIO_OE=0.
  - At the edge ending the beat, `rdata`[8k+7:8k]←DIO_I.
  - When beat 3 completes, go to ACK.
- ACK:
  - nREADY=0 for exactly one cycle. nCSTURF stays 0.
  - For reads, LD_O=`rdata`.
  - If nBLAST=0 at this edge, go to GAP.
  - Otherwise (burst continues), `addr`←`addr`+1, wrapping modulo 256, then go to GAP with `cont`=1.
- GAP:
  - nCSTURF=1, DIO_OE=0, for one cycle.
  - If `cont`=1, clear `cont` and go to ADDR.
  - Otherwise go to IDLE.
- LD_OE=1 from ADDR through ACK of a read, and also in the GAP between burst words of a read. LD_OE=0 otherwise.
- Outputs are decoded from registered state. There are no combinational paths from inputs to outputs.
- nADS arriving while not in IDLE is ignored.
- nCS3=1 with nADS=0 is ignored; that access belongs to another region.

## Timing
- Reset values, applied immediately on nRST=0 from any state:
  - state=IDLE.
  - nREADY=1, nBTERM=1, nCSTURF=1, TURF_WnR=0.
  - DIO_OE=0, DIO_O=0, LD_OE=0, LD_O=0.
  - `beat`=0, `cont`=0.
- Cycle 0 is the edge at which nADS is sampled.
- Write word:
  - ADDR in cycle 1, WDATA in cycles 2–5.
  - nREADY=0 in cycle 6, GAP in cycle 7.
  - The next ADS is accepted at the edge ending cycle 7.
- Read word:
  - ADDR in cycle 1, TA in cycle 2, RDATA in cycles 3–6.
  - nREADY=0 in cycle 7, with LD_O valid.
  - GAP in cycle 8.
- Burst: each additional word costs 7 cycles (write) or 8 cycles (read) from GAP to the next nREADY.
- nCSTURF is low continuously from ADDR through ACK, and high for at least one GAP cycle between words.
- TURF_DIO turnaround:
  - DIO_OE falls at the end of ADDR for reads.
  - The TURF must not drive before TA ends.
  - After RDATA beat 3, the TURF releases during ACK or GAP.
- Address wrap: a burst starting at LA[9:2]=0xFF continues at 0x00.

## Test plan
- Single write, LA[9:2]=0x12, LD=0xA1B2C3D4 → DIO beats 0x12, 0xD4, 0xC3, 0xB2, 0xA1; TURF_WnR=1; nREADY low for exactly one cycle, in cycle 6.
- Single read, LA[9:2]=0x34, TURF model returns bytes 0x78, 0x56, 0x34, 0x12 in RDATA → LD_O=0x12345678 with nREADY low in cycle 7; DIO_OE=0 in cycles 2–6.
- Write burst of 3 words from address 0xFE, with nBLAST asserted on word 3 → address beats 0xFE, 0xFF, 0x00; three nREADY pulses; nCSTURF high for one cycle between words.
- nADS with nCS3=1, followed by an nADS on cycle 4 with nCS3=0 → the first is ignored (nCSTURF stays 1); the second produces a normal transaction.
- nRST pulled low during read RDATA beat 2 → all outputs go to reset values immediately; the next nADS after release runs a complete, correct read.
- nADS pulses during an active write → ignored; exactly one transaction and one nREADY occur.
